// File: rtl/load_store_unit.sv
// Load/store unit: turns an execute-stage memory op into a word-aligned, byte-enabled
// req/ack memory transaction and returns extended load data to writeback.
module load_store_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        srst,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic        ex_we,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_wdata,
    input  logic [4:0]  ex_rd,
    output logic        op_done,
    output logic [1:0]  op_err,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

    state_t         r_state;
    logic [CW-1:0]  r_cnt;
    logic           r_ex_ready;
    logic           r_op_done;
    logic [1:0]     r_op_err;
    logic           r_wb_valid;
    logic [4:0]     r_wb_rd;
    logic [31:0]    r_wb_data;
    logic           r_mem_req;
    logic           r_mem_we;
    logic [31:0]    r_mem_addr;
    logic [3:0]     r_mem_be;
    logic [31:0]    r_mem_wdata;
    logic [2:0]     r_funct3;
    logic [1:0]     r_off;
    logic [4:0]     r_rd;

    logic           w_illegal;
    logic [3:0]     w_be;
    logic [31:0]    w_wdata;
    logic [7:0]     w_byte;
    logic [15:0]    w_half;
    logic [31:0]    w_ld_data;

    // Request decode: legality check and store lane placement
    always_comb begin
        w_illegal = 1'b0;
        w_be      = 4'b1111;
        w_wdata   = ex_wdata;
        case (ex_funct3)
            3'b000:  w_illegal = 1'b0;
            3'b001:  w_illegal = ex_addr[0];
            3'b010:  w_illegal = (ex_addr[1:0] != 2'b00);
            3'b100:  w_illegal = ex_we;
            3'b101:  w_illegal = ex_we | ex_addr[0];
            default: w_illegal = 1'b1;
        endcase
        if (ex_we) begin
            case (ex_funct3[1:0])
                2'b00: begin
                    w_be    = 4'b0001 << ex_addr[1:0];
                    w_wdata = {4{ex_wdata[7:0]}};
                end
                2'b01: begin
                    w_be    = 4'b0011 << {ex_addr[1], 1'b0};
                    w_wdata = {2{ex_wdata[15:0]}};
                end
                default: begin
                    w_be    = 4'b1111;
                    w_wdata = ex_wdata;
                end
            endcase
        end
    end

    // Load lane select and extension, using the offset latched at accept
    always_comb begin
        case (r_off)
            2'd0:    w_byte = mem_rdata[7:0];
            2'd1:    w_byte = mem_rdata[15:8];
            2'd2:    w_byte = mem_rdata[23:16];
            default: w_byte = mem_rdata[31:24];
        endcase
        w_half = r_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (r_funct3)
            3'b000:  w_ld_data = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_ld_data = {{16{w_half[15]}}, w_half};
            3'b100:  w_ld_data = {24'd0, w_byte};
            3'b101:  w_ld_data = {16'd0, w_half};
            default: w_ld_data = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge srst) begin
        if (!srst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_ex_ready  <= 1'b1;
            r_op_done   <= 1'b0;
            r_op_err    <= 2'b00;
            r_wb_valid  <= 1'b0;
            r_wb_rd     <= 5'd0;
            r_wb_data   <= 32'd0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 32'd0;
            r_mem_be    <= 4'd0;
            r_mem_wdata <= 32'd0;
            r_funct3    <= 3'd0;
            r_off       <= 2'd0;
            r_rd        <= 5'd0;
        end else begin
            r_op_done  <= 1'b0;
            r_wb_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (ex_valid) begin
                        r_ex_ready  <= 1'b0;
                        r_cnt       <= '0;
                        r_mem_we    <= ex_we;
                        r_mem_addr  <= {ex_addr[31:2], 2'b00};
                        r_mem_be    <= w_be;
                        r_mem_wdata <= w_wdata;
                        r_funct3    <= ex_funct3;
                        r_off       <= ex_addr[1:0];
                        r_rd        <= ex_rd;
                        if (w_illegal) begin
                            r_state   <= S_DONE;
                            r_op_done <= 1'b1;
                            r_op_err  <= 2'b01;
                        end else begin
                            r_state   <= S_REQ;
                            r_mem_req <= 1'b1;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_ack) begin
                        r_state   <= S_DONE;
                        r_mem_req <= 1'b0;
                        r_op_done <= 1'b1;
                        r_op_err  <= 2'b00;
                        if (!r_mem_we) begin
                            r_wb_valid <= 1'b1;
                            r_wb_rd    <= r_rd;
                            r_wb_data  <= w_ld_data;
                        end
                    end else if ((TIMEOUT != 0) && (r_cnt == CNT_LAST)) begin
                        r_state   <= S_DONE;
                        r_mem_req <= 1'b0;
                        r_op_done <= 1'b1;
                        r_op_err  <= 2'b10;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_ex_ready <= 1'b1;
                end
            endcase
        end
    end

    assign ex_ready  = r_ex_ready;
    assign op_done   = r_op_done;
    assign op_err    = r_op_err;
    assign wb_valid  = r_wb_valid;
    assign wb_rd     = r_wb_rd;
    assign wb_data   = r_wb_data;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_be    = r_mem_be;
    assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: stores, loads, illegal ops, timeout and mid-op reset.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        srst = 1'b0;
    logic        ex_valid = 1'b0;
    logic        ex_ready;
    logic        ex_we = 1'b0;
    logic [2:0]  ex_funct3 = 3'd0;
    logic [31:0] ex_addr = 32'd0;
    logic [31:0] ex_wdata = 32'd0;
    logic [4:0]  ex_rd = 5'd0;
    logic        op_done;
    logic [1:0]  op_err;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'd0;

    int checks = 0;
    int errors = 0;

    // Results of the most recent run_op
    int          r_done_at;
    int          r_req_cycles;
    logic [1:0]  r_err;
    logic        r_wbv;
    logic [31:0] r_wbd;
    logic [4:0]  r_wbr;
    logic [31:0] r_maddr;
    logic [3:0]  r_mbe;
    logic [31:0] r_mwd;
    logic        r_mwe;
    logic        r_ready_next;
    logic        r_done_next;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT(4)) dut (
        .clk(clk), .srst(srst),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_we(ex_we), .ex_funct3(ex_funct3),
        .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_rd(ex_rd),
        .op_done(op_done), .op_err(op_err), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    // Issue one op (accepted at cycle N) and observe cycles N+1.. until op_done.
    // k = wait states before ack (ack in cycle N+1+k); k < 0 never acks.
    task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [4:0] rd, input int k,
                          input logic [31:0] rdata);
        @(negedge clk);
        ex_valid = 1'b1; ex_we = we; ex_funct3 = f3; ex_addr = addr; ex_wdata = wdata; ex_rd = rd;
        @(negedge clk);
        ex_valid = 1'b0;
        r_done_at = -1; r_req_cycles = 0;
        r_err = 2'bxx; r_wbv = 1'bx; r_wbd = 'x; r_wbr = 'x;
        r_maddr = 'x; r_mbe = 'x; r_mwd = 'x; r_mwe = 1'bx;
        for (int c = 1; c <= 40 && r_done_at < 0; c++) begin
            if (mem_req) begin
                r_req_cycles++;
                r_maddr = mem_addr; r_mbe = mem_be; r_mwd = mem_wdata; r_mwe = mem_we;
            end
            if (op_done) begin
                r_done_at = c; r_err = op_err; r_wbv = wb_valid; r_wbd = wb_data; r_wbr = wb_rd;
            end
            mem_ack = (k >= 0) && (c == 1 + k);
            mem_rdata = rdata;
            @(negedge clk);
        end
        mem_ack = 1'b0;
        r_ready_next = ex_ready;
        r_done_next = op_done;
        $display("op we=%0b f3=%03b addr=%08h done_at=%0d req_cycles=%0d err=%02b wb=%0b/%08h",
                 we, f3, addr, r_done_at, r_req_cycles, r_err, r_wbv, r_wbd);
    endtask

    task automatic test_reset;
        srst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (ex_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b want 1", ex_ready); end
        checks++;
        if ({mem_req, mem_we, op_done, op_err, wb_valid} !== 6'd0) begin
            errors++; $display("FAIL reset_ctrl got %06b want 000000", {mem_req, mem_we, op_done, op_err, wb_valid});
        end
        checks++;
        if ({mem_addr, mem_be, mem_wdata, wb_data, wb_rd} !== 105'd0) begin
            errors++; $display("FAIL reset_data got %08h %h %08h %08h %0d want zeros", mem_addr, mem_be, mem_wdata, wb_data, wb_rd);
        end
        srst = 1'b1;
        @(negedge clk);
        $display("reset released");
    endtask

    task automatic test_store_word;
        run_op(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 5'd3, 0, 32'h0);
        checks++; if (r_done_at !== 2) begin errors++; $display("FAIL sw_done_at got %0d want 2", r_done_at); end
        checks++; if (r_err !== 2'b00) begin errors++; $display("FAIL sw_err got %02b want 00", r_err); end
        checks++; if (r_wbv !== 1'b0) begin errors++; $display("FAIL sw_wb_valid got %0b want 0", r_wbv); end
        checks++; if (r_maddr !== 32'h100) begin errors++; $display("FAIL sw_addr got %08h want 00000100", r_maddr); end
        checks++; if (r_mbe !== 4'b1111) begin errors++; $display("FAIL sw_be got %04b want 1111", r_mbe); end
        checks++; if (r_mwd !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_wdata got %08h want deadbeef", r_mwd); end
        checks++; if (r_mwe !== 1'b1) begin errors++; $display("FAIL sw_we got %0b want 1", r_mwe); end
        checks++; if (r_req_cycles !== 1) begin errors++; $display("FAIL sw_req_cycles got %0d want 1", r_req_cycles); end
        checks++; if (r_ready_next !== 1'b1 || r_done_next !== 1'b0) begin
            errors++; $display("FAIL sw_after got ready=%0b done=%0b want 1 0", r_ready_next, r_done_next);
        end
    endtask

    task automatic test_store_sub;
        run_op(1'b1, 3'b000, 32'h103, 32'h000000A5, 5'd0, 1, 32'h0);
        checks++; if (r_mbe !== 4'b1000) begin errors++; $display("FAIL sb_be got %04b want 1000", r_mbe); end
        checks++; if (r_mwd !== 32'hA5A5A5A5) begin errors++; $display("FAIL sb_wdata got %08h want a5a5a5a5", r_mwd); end
        checks++; if (r_maddr !== 32'h100) begin errors++; $display("FAIL sb_addr got %08h want 00000100", r_maddr); end
        checks++; if (r_done_at !== 3) begin errors++; $display("FAIL sb_done_at got %0d want 3", r_done_at); end
        run_op(1'b1, 3'b001, 32'h206, 32'h1234BEEF, 5'd0, 0, 32'h0);
        checks++; if (r_mbe !== 4'b1100) begin errors++; $display("FAIL sh_be got %04b want 1100", r_mbe); end
        checks++; if (r_mwd !== 32'hBEEFBEEF) begin errors++; $display("FAIL sh_wdata got %08h want beefbeef", r_mwd); end
        checks++; if (r_maddr !== 32'h204) begin errors++; $display("FAIL sh_addr got %08h want 00000204", r_maddr); end
    endtask

    task automatic test_loads;
        run_op(1'b0, 3'b000, 32'h101, 32'h0, 5'd9, 3, 32'h12348056);
        checks++; if (r_done_at !== 5) begin errors++; $display("FAIL lb_done_at got %0d want 5", r_done_at); end
        checks++; if (r_wbd !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_data got %08h want ffffff80", r_wbd); end
        checks++; if (r_wbv !== 1'b1 || r_wbr !== 5'd9) begin errors++; $display("FAIL lb_wb got v=%0b rd=%0d want 1 9", r_wbv, r_wbr); end
        checks++; if (r_mbe !== 4'b1111 || r_mwe !== 1'b0) begin errors++; $display("FAIL lb_bus got be=%04b we=%0b want 1111 0", r_mbe, r_mwe); end
        checks++; if (r_req_cycles !== 4) begin errors++; $display("FAIL lb_req_cycles got %0d want 4", r_req_cycles); end
        run_op(1'b0, 3'b100, 32'h101, 32'h0, 5'd10, 0, 32'h12348056);
        checks++; if (r_wbd !== 32'h00000080) begin errors++; $display("FAIL lbu_data got %08h want 00000080", r_wbd); end
        run_op(1'b0, 3'b001, 32'h102, 32'h0, 5'd7, 0, 32'h12348056);
        checks++; if (r_wbd !== 32'h00001234) begin errors++; $display("FAIL lh_data got %08h want 00001234", r_wbd); end
        checks++; if (r_wbr !== 5'd7) begin errors++; $display("FAIL lh_rd got %0d want 7", r_wbr); end
        run_op(1'b0, 3'b001, 32'h100, 32'h0, 5'd1, 0, 32'h12348056);
        checks++; if (r_wbd !== 32'hFFFF8056) begin errors++; $display("FAIL lh0_data got %08h want ffff8056", r_wbd); end
        run_op(1'b0, 3'b101, 32'h100, 32'h0, 5'd2, 0, 32'h12348056);
        checks++; if (r_wbd !== 32'h00008056) begin errors++; $display("FAIL lhu_data got %08h want 00008056", r_wbd); end
        run_op(1'b0, 3'b000, 32'h103, 32'h0, 5'd4, 0, 32'h92348056);
        checks++; if (r_wbd !== 32'hFFFFFF92) begin errors++; $display("FAIL lb3_data got %08h want ffffff92", r_wbd); end
        run_op(1'b0, 3'b010, 32'h104, 32'h0, 5'd31, 2, 32'h12348056);
        checks++; if (r_wbd !== 32'h12348056 || r_wbr !== 5'd31) begin
            errors++; $display("FAIL lw_data got %08h rd=%0d want 12348056 31", r_wbd, r_wbr);
        end
    endtask

    task automatic test_illegal;
        logic [2:0] f3s [4] = '{3'b010, 3'b001, 3'b011, 3'b100};
        logic [31:0] addrs [4] = '{32'h102, 32'h101, 32'h100, 32'h100};
        logic wes [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            run_op(wes[i], f3s[i], addrs[i], 32'h0, 5'd5, 0, 32'h0);
            checks++;
            if (r_done_at !== 1 || r_err !== 2'b01 || r_req_cycles !== 0 || r_wbv !== 1'b0) begin
                errors++;
                $display("FAIL illegal_%0d got done_at=%0d err=%02b req=%0d wbv=%0b want 1 01 0 0",
                         i, r_done_at, r_err, r_req_cycles, r_wbv);
            end
        end
    endtask

    task automatic test_timeout;
        int spurious;
        run_op(1'b0, 3'b010, 32'h300, 32'h0, 5'd6, -1, 32'h55555555);
        checks++; if (r_req_cycles !== 4) begin errors++; $display("FAIL to_req_cycles got %0d want 4", r_req_cycles); end
        checks++; if (r_done_at !== 5 || r_err !== 2'b10) begin
            errors++; $display("FAIL to_done got at=%0d err=%02b want 5 10", r_done_at, r_err);
        end
        checks++; if (r_wbv !== 1'b0) begin errors++; $display("FAIL to_wb_valid got %0b want 0", r_wbv); end
        // now at done+1; late ack arrives two cycles after op_done
        @(negedge clk);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        spurious = 0;
        repeat (4) begin
            if (op_done || mem_req || wb_valid) spurious++;
            @(negedge clk);
        end
        checks++; if (spurious !== 0) begin errors++; $display("FAIL late_ack got %0d busy cycles want 0", spurious); end
        checks++; if (wb_data !== 32'h12348056) begin errors++; $display("FAIL wb_hold got %08h want 12348056", wb_data); end
        $display("late ack checked");
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        ex_valid = 1'b1; ex_we = 1'b1; ex_funct3 = 3'b010; ex_addr = 32'h400; ex_wdata = 32'h11112222;
        @(negedge clk);
        ex_valid = 1'b0;
        @(negedge clk);
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL mid_req_before got %0b want 1", mem_req); end
        #2 srst = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL mid_req_drop got %0b want 0", mem_req); end
        checks++;
        if (ex_ready !== 1'b1 || {mem_we, mem_addr, mem_be, mem_wdata, op_done, op_err} !== 72'd0) begin
            errors++; $display("FAIL mid_outputs got ready=%0b we=%0b addr=%08h be=%04b", ex_ready, mem_we, mem_addr, mem_be);
        end
        @(negedge clk);
        srst = 1'b1;
        checks++; if (ex_ready !== 1'b1) begin errors++; $display("FAIL mid_ready got %0b want 1", ex_ready); end
        run_op(1'b0, 3'b010, 32'h200, 32'h0, 5'd12, 1, 32'hCAFEF00D);
        checks++;
        if (r_done_at !== 3 || r_err !== 2'b00 || r_wbd !== 32'hCAFEF00D || r_maddr !== 32'h200) begin
            errors++; $display("FAIL post_reset_lw got at=%0d err=%02b data=%08h addr=%08h want 3 00 cafef00d 00000200",
                               r_done_at, r_err, r_wbd, r_maddr);
        end
    endtask

    task automatic test_back_to_back;
        // ex_valid held while busy must not start a second op
        int dones;
        @(negedge clk);
        ex_valid = 1'b1; ex_we = 1'b0; ex_funct3 = 3'b011; ex_addr = 32'h0;
        dones = 0;
        repeat (4) begin
            @(negedge clk);
            if (op_done) dones++;
        end
        ex_valid = 1'b0;
        repeat (2) @(negedge clk);
        // accept at cycles 1 and 3 (IDLE,DONE,IDLE,DONE): done in cycles 2 and 4
        checks++; if (dones !== 2) begin errors++; $display("FAIL b2b_dones got %0d want 2", dones); end
        $display("back-to-back illegal ops: %0d completions", dones);
    endtask

    initial begin
        test_reset();
        test_store_word();
        test_store_sub();
        test_loads();
        test_illegal();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
